// File: rtl/bus_dev_fifo.sv
// bus_dev_fifo: decodes device-addressed bus words into a show-ahead FIFO feeding one device.
// Latency: 1 cycle from an accepted word to out/start; 1 word/cycle sustained, no bubbles.
// Backpressure: ready=0 holds the head; matching words arriving while full with no pop are dropped and counted.

module bus_dev_fifo_buf #(
    parameter  int W     = 24,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     wr_dat,
    output logic [W-1:0]     rd_dat,
    output logic [LVL_W-1:0] level
);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Storage carries no reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    assign rd_dat = mem[rd_ptr];

endmodule

module bus_dev_fifo #(
    parameter  int BUS_W     = 32,
    parameter  int ADDR_W    = 2,
    parameter  int PAYLOAD_W = 24,
    parameter  int DEPTH     = 4,
    parameter  int CNT_W     = 8,
    localparam int LVL_W     = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BUS_W-1:0]     in,
    input  logic                 in_valid,
    input  logic [ADDR_W-1:0]    devaddr,
    output logic [PAYLOAD_W-1:0] out,
    output logic                 start,
    input  logic                 ready,
    output logic [LVL_W-1:0]     level,
    output logic                 full,
    output logic                 overflow,
    output logic [CNT_W-1:0]     drop_cnt,
    input  logic                 clr_err
);

    logic                 match;
    logic                 push;
    logic                 pop;
    logic                 drop;
    logic [PAYLOAD_W-1:0] head;

    assign match = in_valid && (in[BUS_W-1 -: ADDR_W] == devaddr);
    assign pop   = start && ready;
    assign push  = match && (!full || pop);
    assign drop  = match && full && !pop;

    generate
        if (PAYLOAD_W < BUS_W - ADDR_W) begin : g_gap
            logic unused_gap;
            assign unused_gap = ^in[BUS_W-ADDR_W-1:PAYLOAD_W];
        end
    endgenerate

    bus_dev_fifo_buf #(
        .W     (PAYLOAD_W),
        .DEPTH (DEPTH)
    ) u_buf (
        .clk    (clk),
        .rst    (rst),
        .push   (push),
        .pop    (pop),
        .wr_dat (in[PAYLOAD_W-1:0]),
        .rd_dat (head),
        .level  (level)
    );

    assign start = (level != '0);
    assign full  = (level == LVL_W'(DEPTH));
    assign out   = start ? head : '0;

    // A drop in the same cycle as clr_err wins: the clear lands first, then this drop counts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (clr_err) begin
                drop_cnt <= CNT_W'(1);
            end else if (drop_cnt != '1) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end else if (clr_err) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end
    end

endmodule

// File: doc/bus_dev_fifo.md
# bus_dev_fifo

Parametrised device-side bus connector. It decodes command words from the shared 32-bit system bus by a device-address field and buffers the matching payloads in a small FIFO. It presents them to the device (e.g. the G10k graphics core) through a valid/ready handshake. It supersedes the single-register pass-through connector: words are no longer lost when the device is busy, and an explicit `in_valid` stops an idle all-zero bus from addressing device 0. Overflow is reported through a sticky flag and a drop counter.

## Interface
Parameters:
- `BUS_W`, 32: bus word width.
- `ADDR_W`, 2: device-address field width, taken from `in[BUS_W-1 -: ADDR_W]`.
- `PAYLOAD_W`, 24: payload width, taken from `in[PAYLOAD_W-1:0]`. Must satisfy PAYLOAD_W ≤ BUS_W−ADDR_W.
- `DEPTH`, 4: FIFO entries. Must be a power of two, ≥2.
- `CNT_W`, 8: drop counter width.

Ports:
- `clk` in 1: the single clock. All state changes on the rising edge.
- `rst` in 1: asynchronous, active-low reset. `rst`=0 resets immediately; release is synchronous to `clk` at the system level.
- `in` in BUS_W: bus word.
- `in_valid` in 1: `in` carries a command this cycle.
- `devaddr` in ADDR_W: this device's address. Quasi-static.
- `out` out PAYLOAD_W: FIFO head payload. Forced to 0 when `start`=0.
- `start` out 1: `out` is valid (FIFO not empty).
- `ready` in 1: the device takes `out` this cycle.
- `level` out $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `full` out 1: `level`==DEPTH.
- `overflow` out 1: sticky; set when a matching word was dropped.
- `drop_cnt` out CNT_W: number of dropped words, saturating.
- `clr_err` in 1: clears `overflow` and `drop_cnt`.

## Operation
- match = `in_valid` && (`in[BUS_W-1 -: ADDR_W]` == `devaddr`). Non-matching or invalid words are ignored and cause no state change.
- push = match && (!full || pop). pop = `start` && `ready`.
- Storage: DEPTH×PAYLOAD_W array with write and read pointers of $clog2(DEPTH) bits. Pointers wrap modulo DEPTH.
- The occupancy counter tracks pushes and pops:
  - push only: `level`+1.
  - pop only: `level`−1.
  - push and pop together: unchanged.
- Show-ahead output: `out` = mem[rd_ptr] when `level`≠0, otherwise 0. `start` = (`level`≠0). Both are decoded from registered state only; there is no combinational path from `in`, `in_valid` or `ready`.
- Full handling:
  - A word that arrives while full with no pop in the same cycle is dropped.
  - A drop sets `overflow` to 1 and increments `drop_cnt`. `drop_cnt` saturates at 2^CNT_W−1.
  - A word that arrives while full with a pop in the same cycle is accepted. No drop occurs.
- `ready` while empty has no effect. Pointers must not move.
- `clr_err`:
  - On its own, `clr_err` clears `overflow` to 0 and `drop_cnt` to 0.
  - If a drop happens in the same cycle, the drop wins: `overflow`=1, `drop_cnt`=1.
- Reset (`rst`=0, at any time including mid-burst): pointers, `level`, `overflow` and `drop_cnt` go to 0. `start`=0, `out`=0, `full`=0. Buffered contents are discarded; array contents need not be cleared.

## Timing
- Latency: a matching word accepted at edge N while the FIFO is empty appears on `out` with `start`=1 after edge N. This is 1 cycle, the same as the legacy connector.
- Pop: with `start`&&`ready` sampled at edge N, the next entry (or `start`=0) is visible after edge N.
- Sustained throughput is 1 word/cycle with `ready` held high. There is no bubble between back-to-back words.
- `level`, `full`, `overflow` and `drop_cnt` are registered and update at the same edge as the push or pop that changes them.
- After `rst` is released, the first matching word may be accepted at the first clock edge.

## Test plan
- Reset and idle:
  - Stimulus: assert `rst`=0 mid-burst with `level`=3.
  - Required: immediately `start`=0, `out`=0, `level`=0, `overflow`=0. `in`=0 with `in_valid`=0 and `devaddr`=0 must not push.
- Decode:
  - Stimulus: `devaddr`=2; send `in`=0x8012_3456 with `in_valid`=1, then 0x4000_0001.
  - Required: only 0x12_3456 is buffered. `start`=1 one cycle later, `level`=1.
- Back-pressure and order:
  - Stimulus: push 0xA,0xB,0xC,0xD with `ready`=0 (DEPTH=4).
  - Required: `full`=1, `level`=4.
  - Stimulus: then `ready`=1.
  - Required: `out` = A,B,C,D on consecutive cycles, then `start`=0, `out`=0.
- Overflow:
  - Stimulus: while full with `ready`=0, push 3 more words.
  - Required: `overflow`=1, `drop_cnt`=3, contents still A..D.
  - Stimulus: with CNT_W=2, push 5 drops.
  - Required: `drop_cnt` saturates at 3.
- Simultaneous events:
  - Stimulus: while full, push and pop in the same cycle.
  - Required: no drop, `level` stays 4, the new word is last out.
  - Stimulus: `clr_err` in the same cycle as a drop.
  - Required: `overflow`=1, `drop_cnt`=1.
- Wrap-around:
  - Stimulus: 3×DEPTH+1 words with random `ready`.
  - Required: output order and count match a reference queue exactly.
